// File: rtl/toggle_pkg.sv
// Shared definitions for toggle-encoded event crossings: default widths,
// decoder FSM states and the INIT window length.
package toggle_pkg;

  localparam int CNT_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int INIT_LEN_DEF    = SYNC_STAGES_DEF + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } toggle_state_e;

  // The chain plus the history flop must fill before edges mean anything.
  function automatic int init_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level, cleared to 0 by
// the synchronous active-low reset.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk0,
  input  logic rstn0,
  input  logic d_in,
  output logic d_out
);

  logic [DEPTH-1:0] chain_d;
  logic [DEPTH-1:0] chain_q;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d_in};
  end

  always_ff @(posedge clk0) begin
    if (!rstn0) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign d_out = chain_q[DEPTH-1];

endmodule

// File: rtl/toggle_decoder.sv
// Turns a toggle-encoded level back into discrete events, buffers them in a
// saturating counter and hands them out one per valid/ready transfer.
module toggle_decoder
  import toggle_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk0,
  input  logic             rstn0,
  input  logic             q0,
  output logic             ev_valid0,
  input  logic             ev_ready0,
  output logic [CNT_W-1:0] pend0,
  output logic             ovf0,
  input  logic             ovf_clr0,
  output logic             level0
);

  localparam int INIT_LEN = init_len(SYNC_STAGES);
  localparam int ICW      = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [ICW-1:0]   INIT_LAST = ICW'(INIT_LEN - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

  logic             sync_out;
  logic             edge_det;
  logic             inc;
  logic             dec;
  logic             set_ovf;

  toggle_state_e    state_d,    state_q;
  logic [ICW-1:0]   init_cnt_d, init_cnt_q;
  logic             prev_d,     prev_q;
  logic [CNT_W-1:0] pend_d,     pend_q;
  logic             ovf_d,      ovf_q;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk0  (clk0),
    .rstn0 (rstn0),
    .d_in  (q0),
    .d_out (sync_out)
  );

  assign edge_det = (sync_out != prev_q);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = sync_out;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    inc        = 1'b0;
    dec        = 1'b0;
    set_ovf    = 1'b0;

    case (state_q)
      // Edges seen while the chain fills are the reset-time baseline.
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        inc = edge_det;
        dec = ev_valid0 && ev_ready0;
        if (inc && !dec) begin
          if (pend_q == PEND_MAX) begin
            set_ovf = 1'b1;
          end else begin
            pend_d = pend_q + 1'b1;
          end
        end else if (dec && !inc) begin
          pend_d = pend_q - 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (set_ovf) begin
      ovf_d = 1'b1;
    end else if (ovf_clr0) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstn0) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ev_valid0 = (pend_q != '0);
  assign pend0     = pend_q;
  assign ovf0      = ovf_q;
  assign level0    = sync_out;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder: baseline after reset, latency, accumulation,
// saturation/overflow, simultaneous inc/dec at max and reset mid-stream.
module tb_toggle_decoder;

  logic       clk0;
  logic       rstn0;
  logic       q0;
  logic       ev_valid0;
  logic       ev_ready0;
  logic [3:0] pend0;
  logic       ovf0;
  logic       ovf_clr0;
  logic       level0;

  int vectorCount   = 0;
  int missCount     = 0;

  toggle_decoder #(
    .CNT_W       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk0      (clk0),
    .rstn0     (rstn0),
    .q0        (q0),
    .ev_valid0 (ev_valid0),
    .ev_ready0 (ev_ready0),
    .pend0     (pend0),
    .ovf0      (ovf0),
    .ovf_clr0  (ovf_clr0),
    .level0    (level0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive all inputs at once, then let the given number of edges pass.
  task automatic applyStimulus(input logic qv, input logic rdy, input logic clr,
                               input int cycles);
    q0        = qv;
    ev_ready0 = rdy;
    ovf_clr0  = clr;
    tick(cycles);
  endtask

  initial begin
    rstn0     = 1'b0;
    q0        = 1'b1;
    ev_ready0 = 1'b0;
    ovf_clr0  = 1'b0;

    // Reset baseline with q0 held high
    tick(2);
    checkOutput("rst_pend",  pend0,     0);
    checkOutput("rst_valid", ev_valid0, 0);
    checkOutput("rst_ovf",   ovf0,      0);
    checkOutput("rst_level", level0,    0);
    rstn0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("init_pend",  pend0,     0);
      checkOutput("init_valid", ev_valid0, 0);
    end
    checkOutput("base_level", level0, 1);
    tick(3);
    checkOutput("base_pend", pend0, 0);

    // Single event with exact latency
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("lat_k_pend", pend0, 0);
    tick(1);
    checkOutput("lat_k1_level", level0, 0);
    checkOutput("lat_k1_pend",  pend0,  0);
    tick(1);
    checkOutput("lat_k2_pend",  pend0,     1);
    checkOutput("lat_k2_valid", ev_valid0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    ev_ready0 = 1'b0;
    checkOutput("single_drain_pend",  pend0,     0);
    checkOutput("single_drain_valid", ev_valid0, 0);

    // Accumulate five events, then drain one per cycle
    for (int i = 0; i < 5; i++) applyStimulus(~q0, 1'b0, 1'b0, 3);
    checkOutput("acc_pend", pend0, 5);
    ev_ready0 = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick(1);
      checkOutput("acc_drain", pend0, i);
    end
    tick(1);
    checkOutput("no_underflow", pend0, 0);
    checkOutput("no_underflow_valid", ev_valid0, 0);
    ev_ready0 = 1'b0;

    // Saturation: 16 events into a 15-deep counter
    for (int i = 0; i < 16; i++) applyStimulus(~q0, 1'b0, 1'b0, 3);
    checkOutput("sat_pend", pend0, 15);
    checkOutput("sat_ovf",  ovf0,  1);
    applyStimulus(q0, 1'b0, 1'b1, 1);
    ovf_clr0 = 1'b0;
    checkOutput("clr_ovf",  ovf0,  0);
    checkOutput("clr_pend", pend0, 15);

    // Set and clear in the same cycle: set wins
    applyStimulus(~q0, 1'b0, 1'b0, 2);
    applyStimulus(q0, 1'b0, 1'b1, 1);
    ovf_clr0 = 1'b0;
    checkOutput("setclr_ovf",  ovf0,  1);
    checkOutput("setclr_pend", pend0, 15);
    applyStimulus(q0, 1'b0, 1'b1, 1);
    ovf_clr0 = 1'b0;
    checkOutput("reclr_ovf", ovf0, 0);

    // Increment and decrement together at max
    applyStimulus(~q0, 1'b0, 1'b0, 2);
    applyStimulus(q0, 1'b1, 1'b0, 1);
    ev_ready0 = 1'b0;
    checkOutput("incdec_pend", pend0, 15);
    checkOutput("incdec_ovf",  ovf0,  0);

    // Overflow again, then drain to 3 before resetting mid-stream
    applyStimulus(~q0, 1'b0, 1'b0, 3);
    checkOutput("ovf2", ovf0, 1);
    applyStimulus(q0, 1'b1, 1'b0, 12);
    ev_ready0 = 1'b0;
    checkOutput("pre_rst_pend", pend0, 3);
    checkOutput("pre_rst_ovf",  ovf0,  1);
    rstn0 = 1'b0;
    q0    = ~q0;
    tick(1);
    rstn0 = 1'b1;
    checkOutput("mid_rst_pend", pend0, 0);
    checkOutput("mid_rst_ovf",  ovf0,  0);
    tick(10);
    checkOutput("absorb_pend",  pend0,  0);
    checkOutput("absorb_level", level0, q0);

    // Decoder still counts after the reset
    applyStimulus(~q0, 1'b0, 1'b0, 3);
    checkOutput("post_rst_pend", pend0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
# toggle_decoder

Receive-side counterpart of the team's T flip-flop toggle stage. The block takes a level signal `q0` that flips once per event and may come from another clock domain. It synchronises `q0`, detects each transition, and turns it back into discrete events. Pending events are buffered in a saturating counter and handed to the consumer one per valid/ready transfer. The block sits between any toggle-encoded status line and local control logic.

## Interface
- `CNT_W`, 4: width of the pending-event counter; maximum pending count is 2^CNT_W − 1.
- `SYNC_STAGES`, 2: synchroniser depth on `q0`; must be 2 or more.

Ports:
- `clk0`  in  1  single clock; all state changes on its rising edge.
- `rstn0`  in  1  reset, synchronous, active-low.
- `q0`  in  1  toggle-encoded input level; asynchronous to `clk0`.
- `ev_valid0`  out  1  at least one event is pending.
- `ev_ready0`  in  1  consumer accepts one event when asserted together with `ev_valid0`.
- `pend0`  out  CNT_W  current pending-event count.
- `ovf0`  out  1  sticky flag: an event was lost because the counter was saturated.
- `ovf_clr0`  in  1  one-cycle pulse that clears `ovf0`.
- `level0`  out  1  synchronised copy of `q0`.

## Operation
- **Input path.** `q0` passes through a `SYNC_STAGES`-deep flop chain, then one history flop `prev`.
  - `edge = sync_out != prev`.
  - `level0 = sync_out`.
- **FSM states: INIT, RUN.**
  - Reset puts the FSM in INIT.
  - INIT lasts `SYNC_STAGES`+1 cycles, counted by a small counter.
  - During INIT the chain and `prev` load normally. `edge` is ignored, so the reset-time level of `q0` becomes the baseline and generates no event.
  - INIT → RUN when the counter expires.
  - RUN → INIT only through reset.
- **Counter update in RUN, evaluated each cycle.** Let `inc = edge`, `dec = ev_valid0 && ev_ready0`.
  - inc only: `pend0`+1. If `pend0` is already at maximum, `pend0` holds and `ovf0` is set to 1.
  - dec only: `pend0`−1.
  - inc and dec together: `pend0` unchanged and `ovf0` not set, even when `pend0` is at maximum.
  - Neither: hold.
- **Outputs.**
  - `ev_valid0 = (pend0 != 0)`, decoded from the register; no combinational path from `ev_ready0`.
  - `ev_ready0` is don't-care while `ev_valid0` = 0 and never makes `pend0` underflow.
- **Overflow flag.**
  - `ovf_clr0` clears `ovf0` on the next edge.
  - Same-cycle set and clear: set wins.
- **Width rules.** `pend0` is unsigned, saturates at the maximum and never wraps. Decrement never goes below 0.

## Timing
- **Reset values** (`rstn0` = 0 at a rising edge):
  - `pend0` = 0, `ev_valid0` = 0, `ovf0` = 0.
  - FSM = INIT, INIT counter = 0.
  - Sync chain and `prev` = 0, so `level0` = 0.
- **Reset mid-operation.** Pending events and `ovf0` are discarded. Any `q0` toggle during the following INIT window is absorbed into the baseline.
- **Latency, `SYNC_STAGES` = 2.**
  - `q0` changes and is stable before edge k.
  - `level0` changes after edge k+1.
  - `pend0` increments and `ev_valid0` rises after edge k+2, i.e. 3 edges.
- **Throughput.**
  - One accepted event per cycle.
  - Detection of at most one transition per cycle. `q0` must hold each level for at least 2 `clk0` cycles, or toggles may merge; this is the protocol requirement on the sender.
- **Handshake.** Transfer completes on the edge where both `ev_valid0` and `ev_ready0` are high. `pend0` reflects it after that edge.

## Structure
- **Shared package `toggle_pkg`:**
  - default `CNT_W`;
  - FSM state enum `{ST_INIT, ST_RUN}`;
  - localparam for INIT length (`SYNC_STAGES`+1).
- **Sub-module `sync_chain`:**
  - parameterised depth, reset to 0 by `rstn0`;
  - reused by other toggle-domain crossings.
- **Top `toggle_decoder`:** edge detect, FSM, counter, overflow flag.

## Test plan
- **Reset baseline.** Hold `q0` = 1 through reset and INIT. → `pend0` = 0 and `ev_valid0` = 0 throughout; `level0` = 1 after INIT.
- **Single event.** Toggle `q0` 0→1 before edge k, with `ev_ready0` = 0. → `ev_valid0` = 1 and `pend0` = 1 after edge k+2. Pulse `ev_ready0` once → `pend0` = 0, `ev_valid0` = 0.
- **Accumulation.** Toggle `q0` 5 times, each level held 3 cycles, with `ev_ready0` = 0. → `pend0` = 5. Then set `ev_ready0` = 1 → exactly 5 transfers, one per cycle.
- **Saturation.** With `CNT_W` = 4 and `ev_ready0` = 0, toggle 16 times. → `pend0` = 15 and `ovf0` = 1. `ovf_clr0` pulse → `ovf0` = 0, `pend0` still 15.
- **Simultaneous inc/dec at max.** `pend0` = 15, `ev_ready0` = 1, toggle arrives the same cycle. → `pend0` = 15, `ovf0` stays 0.
- **Reset mid-stream.** `pend0` = 3, `ovf0` = 1, assert `rstn0` = 0 for one cycle while `q0` toggles. → `pend0` = 0, `ovf0` = 0, and no event from toggles inside INIT.
